// File: rtl/field_select.sv
// Field/digit selector for the set-time UI: steps an index 0..N_FIELDS-1 from
// debounced buttons, with hold-to-auto-repeat, wrap/saturate ends, idle timeout and direct load.
module field_select #(
    parameter int N_FIELDS      = 4,
    parameter int VAL_W         = 2,
    parameter int RESET_VAL     = 0,
    parameter bit SATURATE      = 1'b0,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_RATE   = 100,
    parameter int TIMEOUT_TICKS = 0,
    parameter int CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ena,
    input  logic             i_tick,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    input  logic [VAL_W-1:0] i_load_val,
    output logic [VAL_W-1:0] o_val,
    output logic             o_step,
    output logic             o_wrap,
    output logic             o_timeout,
    output logic             o_repeating
);

    localparam logic [VAL_W-1:0] MAX_VAL      = VAL_W'(N_FIELDS - 1);
    localparam logic [VAL_W-1:0] HOME_VAL     = VAL_W'(RESET_VAL);
    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST    = CNT_W'(REPEAT_RATE - 1);
    localparam bit               TIMEOUT_EN   = (TIMEOUT_TICKS > 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_EN ? TIMEOUT_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_LOCK
    } state_t;

    state_t           state_q, state_d;
    logic             dir_up_q, dir_up_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             inc_q, dec_q;
    logic [VAL_W-1:0] val_q, val_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             tout_q, tout_d;
    logic             rep_q;

    logic             inc_press, dec_press;
    logic             active_lvl, other_press;
    logic             step_req, step_up;
    logic             at_end;
    logic [VAL_W-1:0] step_val;
    logic [VAL_W-1:0] load_clamped;
    logic             timeout_fire;

    // History regs come out of reset high, so a button held through reset
    // only counts once it has been released and pressed again.
    assign inc_press   = i_inc & ~inc_q;
    assign dec_press   = i_dec & ~dec_q;
    assign active_lvl  = dir_up_q ? i_inc : i_dec;
    assign other_press = dir_up_q ? dec_press : inc_press;

    // Button FSM: decides when a step is requested and in which direction.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d  = state_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        step_req = 1'b0;
        step_up  = dir_up_q;

        if (!i_ena) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_inc && i_dec) begin
                        state_d = ST_LOCK;
                    end else if (inc_press || dec_press) begin
                        step_req = 1'b1;
                        step_up  = inc_press;
                        dir_up_d = inc_press;
                        cnt_d    = '0;
                        state_d  = ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!active_lvl) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (other_press) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end else if (i_tick) begin
                        if (cnt_q == ((state_q == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
                            step_req = 1'b1;
                            cnt_d    = '0;
                            state_d  = ST_REPEAT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_LOCK: begin
                    if (!i_inc && !i_dec) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // End handling: at an end the step either wraps or is blocked, and
    // o_wrap reports both cases.
    always_comb begin
        at_end   = step_up ? (val_q == MAX_VAL) : (val_q == '0);
        step_val = val_q;
        if (at_end) begin
            if (!SATURATE) begin
                step_val = step_up ? '0 : MAX_VAL;
            end
        end else begin
            step_val = step_up ? val_q + VAL_W'(1) : val_q - VAL_W'(1);
        end
    end

    assign load_clamped = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;

    // Idle timeout counts only while the FSM rests in IDLE with no button held.
    always_comb begin
        tcnt_d       = tcnt_q;
        timeout_fire = 1'b0;
        if (!TIMEOUT_EN || !i_ena) begin
            tcnt_d = '0;
        end else if (i_load || inc_press || dec_press || step_req) begin
            tcnt_d = '0;
        end else if (state_q == ST_IDLE && !i_inc && !i_dec && i_tick) begin
            if (tcnt_q == TIMEOUT_LAST) begin
                timeout_fire = 1'b1;
                tcnt_d       = '0;
            end else begin
                tcnt_d = tcnt_q + CNT_W'(1);
            end
        end
    end

    // Load beats a same-cycle step; the FSM still advances on its own.
    always_comb begin
        val_d  = val_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        tout_d = 1'b0;
        if (i_ena) begin
            if (i_load) begin
                val_d = load_clamped;
            end else if (step_req) begin
                val_d  = step_val;
                step_d = (step_val != val_q);
                wrap_d = at_end;
            end else if (timeout_fire) begin
                val_d  = HOME_VAL;
                tout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_reset) begin
            state_q  <= ST_IDLE;
            dir_up_q <= 1'b1;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            inc_q    <= 1'b1;
            dec_q    <= 1'b1;
            val_q    <= HOME_VAL;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
            tout_q   <= 1'b0;
            rep_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_up_q <= dir_up_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            inc_q    <= i_inc;
            dec_q    <= i_dec;
            val_q    <= val_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
            tout_q   <= tout_d;
            rep_q    <= (state_d == ST_REPEAT);
        end
    end

    assign o_val       = val_q;
    assign o_step      = step_q;
    assign o_wrap      = wrap_q;
    assign o_timeout   = tout_q;
    assign o_repeating = rep_q;

endmodule

// File: tb/tb_field_select.sv
// Bench for field_select: two configurations (wrap+timeout, saturate) share one
// stimulus stream and are compared every cycle against a hold-time model.
module tb_field_select;

    logic       clk = 1'b0;
    logic       rst, ena, tick, inc, dec, load;
    logic [2:0] load_val;

    logic [2:0] w_val, s_val;
    logic       w_step, w_wrap, w_tout, w_rep;
    logic       s_step, s_wrap, s_tout, s_rep;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    field_select #(
        .N_FIELDS(4), .VAL_W(3), .RESET_VAL(0), .SATURATE(1'b0),
        .REPEAT_DELAY(3), .REPEAT_RATE(2), .TIMEOUT_TICKS(5), .CNT_W(8)
    ) dut_w (
        .i_clk(clk), .i_reset(rst), .i_ena(ena), .i_tick(tick),
        .i_inc(inc), .i_dec(dec), .i_load(load), .i_load_val(load_val),
        .o_val(w_val), .o_step(w_step), .o_wrap(w_wrap),
        .o_timeout(w_tout), .o_repeating(w_rep)
    );

    field_select #(
        .N_FIELDS(6), .VAL_W(3), .RESET_VAL(1), .SATURATE(1'b1),
        .REPEAT_DELAY(4), .REPEAT_RATE(3), .TIMEOUT_TICKS(0), .CNT_W(8)
    ) dut_s (
        .i_clk(clk), .i_reset(rst), .i_ena(ena), .i_tick(tick),
        .i_inc(inc), .i_dec(dec), .i_load(load), .i_load_val(load_val),
        .o_val(s_val), .o_step(s_step), .o_wrap(s_wrap),
        .o_timeout(s_tout), .o_repeating(s_rep)
    );

    typedef struct {
        int n; int rv; bit sat; int rd; int rr; int to;
    } cfg_t;

    // held: 0 none, 1 inc, 2 dec; ticks counts every tick since the press.
    typedef struct {
        int val; bit inc_h; bit dec_h; int held; bit locked;
        int ticks; int idle; bit step; bit wrap; bit tout; bit rep;
    } mst_t;

    localparam cfg_t CW = '{n: 4, rv: 0, sat: 1'b0, rd: 3, rr: 2, to: 5};
    localparam cfg_t CS = '{n: 6, rv: 1, sat: 1'b1, rd: 4, rr: 3, to: 0};

    function automatic mst_t model_next(cfg_t c, mst_t s, bit r, bit en, bit tk,
                                        bit bi, bit bd, bit ld, int lv);
        mst_t n = s;
        bit inc_p, dec_p, do_step, up, act, oth, was_idle, fire;
        inc_p    = bi && !s.inc_h;
        dec_p    = bd && !s.dec_h;
        n.inc_h  = bi;
        n.dec_h  = bd;
        n.step   = 0; n.wrap = 0; n.tout = 0;
        do_step  = 0; fire = 0;
        up       = (s.held == 1);
        was_idle = (s.held == 0) && !s.locked;
        if (r) begin
            n.val = c.rv; n.inc_h = 1; n.dec_h = 1; n.held = 0; n.locked = 0;
            n.ticks = 0; n.idle = 0; n.rep = 0;
            return n;
        end
        if (!en) begin
            n.held = 0; n.locked = 0; n.ticks = 0; n.idle = 0; n.rep = 0;
            return n;
        end
        if (s.locked) begin
            if (!bi && !bd) n.locked = 0;
        end else if (s.held == 0) begin
            if (bi && bd) n.locked = 1;
            else if (inc_p) begin do_step = 1; up = 1; n.held = 1; n.ticks = 0; end
            else if (dec_p) begin do_step = 1; up = 0; n.held = 2; n.ticks = 0; end
        end else begin
            act = (s.held == 1) ? bi : bd;
            oth = (s.held == 1) ? dec_p : inc_p;
            if (!act) n.held = 0;
            else if (oth) begin n.held = 0; n.locked = 1; end
            else if (tk) begin
                n.ticks = s.ticks + 1;
                if (n.ticks == c.rd || (n.ticks > c.rd && (n.ticks - c.rd) % c.rr == 0))
                    do_step = 1;
            end
        end
        n.rep = (n.held != 0) && (n.ticks >= c.rd);
        if (c.to > 0) begin
            if (ld || inc_p || dec_p || do_step) n.idle = 0;
            else if (was_idle && !bi && !bd && tk) begin
                n.idle = s.idle + 1;
                if (n.idle == c.to) begin n.idle = 0; fire = 1; end
            end
        end
        if (ld) begin
            n.val = (lv > c.n - 1) ? c.n - 1 : lv;
        end else if (do_step) begin
            if (up && s.val == c.n - 1) begin
                n.wrap = 1;
                if (!c.sat) begin n.val = 0; n.step = 1; end
            end else if (!up && s.val == 0) begin
                n.wrap = 1;
                if (!c.sat) begin n.val = c.n - 1; n.step = 1; end
            end else begin
                n.val  = up ? s.val + 1 : s.val - 1;
                n.step = 1;
            end
        end else if (fire) begin
            n.val = c.rv; n.tout = 1;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    mst_t mw, ms;

    always @(posedge clk) begin
        mw = model_next(CW, mw, rst, ena, tick, inc, dec, load, int'(load_val));
        ms = model_next(CS, ms, rst, ena, tick, inc, dec, load, int'(load_val));
        #1;
        check("w_val",  32'(w_val),  32'(mw.val));
        check("w_step", 32'(w_step), 32'(mw.step));
        check("w_wrap", 32'(w_wrap), 32'(mw.wrap));
        check("w_tout", 32'(w_tout), 32'(mw.tout));
        check("w_rep",  32'(w_rep),  32'(mw.rep));
        check("s_val",  32'(s_val),  32'(ms.val));
        check("s_step", 32'(s_step), 32'(ms.step));
        check("s_wrap", 32'(s_wrap), 32'(ms.wrap));
        check("s_tout", 32'(s_tout), 32'(ms.tout));
        check("s_rep",  32'(s_rep),  32'(ms.rep));
    end

    task automatic drive(input bit bi, input bit bd, input bit tk,
                         input bit ld = 1'b0, input logic [2:0] lv = 3'd0);
        inc = bi; dec = bd; tick = tk; load = ld; load_val = lv;
        @(posedge clk);
        #2;
    endtask

    int steps;
    bit tout_seen;

    initial begin
        rst = 1'b1; ena = 1'b1; tick = 1'b0; inc = 1'b0; dec = 1'b0;
        load = 1'b0; load_val = 3'd0;
        drive(0, 0, 0);
        drive(0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0);
        check("reset_w_val", 32'(w_val), 0);
        check("reset_s_val", 32'(s_val), 1);
        drive(0, 0, 0);

        // Wrap: 0 -> 1,2,3,0 with o_wrap on the last step only; dec at 0 -> 3.
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 0);
            check("wrap_inc_val",  32'(w_val),  32'(k % 4));
            check("wrap_inc_step", 32'(w_step), 1);
            check("wrap_inc_wrap", 32'(w_wrap), (k == 4) ? 1 : 0);
            drive(0, 0, 0);
        end
        drive(0, 1, 0);
        check("wrap_dec_val",  32'(w_val),  3);
        check("wrap_dec_wrap", 32'(w_wrap), 1);
        check("wrap_dec_step", 32'(w_step), 1);
        drive(0, 0, 0);

        // Saturate: s went 1->5 then 4; inc to 5, inc again is blocked.
        drive(1, 0, 0);
        drive(0, 0, 0);
        drive(1, 0, 0);
        check("sat_top_val",  32'(s_val),  5);
        check("sat_top_wrap", 32'(s_wrap), 1);
        check("sat_top_step", 32'(s_step), 0);
        drive(0, 0, 0);
        drive(0, 0, 0, 1'b1, 3'd0);
        drive(0, 1, 0);
        check("sat_bot_val",  32'(s_val),  0);
        check("sat_bot_wrap", 32'(s_wrap), 1);
        check("sat_bot_step", 32'(s_step), 0);
        drive(0, 0, 0);

        // Auto-repeat: hold inc over 9 ticks -> steps at press, 3, 5, 7, 9.
        drive(0, 0, 0, 1'b1, 3'd0);
        drive(1, 0, 0);
        steps = int'(w_step);
        for (int t = 1; t <= 9; t++) begin
            drive(1, 0, 1);
            steps += int'(w_step);
            if (t == 2) check("rep_before", 32'(w_rep), 0);
            if (t == 3) begin
                check("rep_first", 32'(w_rep), 1);
                check("rep_first_val", 32'(w_val), 2);
            end
            drive(1, 0, 0);
            steps += int'(w_step);
        end
        check("rep_val",   32'(w_val), 1);
        check("rep_steps", 32'(steps), 5);
        check("rep_held",  32'(w_rep), 1);
        drive(0, 0, 0);
        check("rep_release", 32'(w_rep), 0);

        // Lock: both pressed, release dec only, keep ticking -> no steps.
        drive(1, 1, 0);
        steps = int'(w_step);
        for (int t = 0; t < 5; t++) begin
            drive(1, 0, 1);
            steps += int'(w_step);
        end
        check("lock_steps", 32'(steps), 0);
        check("lock_val",   32'(w_val), 1);
        drive(0, 0, 0);
        drive(1, 0, 0);
        check("unlock_val",  32'(w_val),  2);
        check("unlock_step", 32'(w_step), 1);
        drive(0, 0, 0);

        // Timeout after 5 idle ticks; a press before the 5th restarts it.
        drive(0, 0, 0, 1'b1, 3'd2);
        for (int t = 1; t <= 5; t++) begin
            drive(0, 0, 1);
            if (t < 5) check("to_wait", 32'(w_tout), 0);
        end
        check("to_val",    32'(w_val),  0);
        check("to_pulse",  32'(w_tout), 1);
        check("to_off_s",  32'(s_val),  2);
        drive(0, 0, 0);
        check("to_oneshot", 32'(w_tout), 0);
        drive(0, 0, 0, 1'b1, 3'd2);
        for (int t = 1; t <= 3; t++) drive(0, 0, 1);
        drive(1, 0, 1);
        drive(0, 0, 0);
        tout_seen = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            drive(0, 0, 1);
            tout_seen |= w_tout;
        end
        check("to_restart_none", 32'(tout_seen), 0);
        check("to_restart_val",  32'(w_val),     3);
        drive(0, 0, 1);
        check("to_restart_fire", 32'(w_tout), 1);
        check("to_restart_home", 32'(w_val),  0);

        // Load clamp, load beats a press, button held through reset.
        drive(0, 0, 0, 1'b1, 3'd7);
        check("load_clamp_w", 32'(w_val), 3);
        check("load_clamp_s", 32'(s_val), 5);
        drive(1, 0, 0, 1'b1, 3'd1);
        check("load_win_val",  32'(w_val),  1);
        check("load_win_step", 32'(w_step), 0);
        drive(0, 0, 0);
        rst = 1'b1;
        drive(1, 0, 0);
        drive(1, 0, 0);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) drive(1, 0, 1);
        check("held_rst_val",  32'(w_val),  0);
        check("held_rst_step", 32'(w_step), 0);
        drive(0, 0, 0);
        drive(1, 0, 0);
        check("repress_val", 32'(w_val), 1);
        drive(0, 0, 0);

        // Disabled block ignores presses.
        ena = 1'b0;
        drive(1, 0, 0);
        check("ena_off_val", 32'(w_val), 1);
        drive(0, 0, 0);
        ena = 1'b1;
        drive(0, 0, 0);

        // Randomised phase against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) inc = ~inc;
            if ($urandom_range(0, 9) == 0) dec = ~dec;
            tick     = ($urandom_range(0, 2) == 0);
            load     = ($urandom_range(0, 49) == 0);
            load_val = 3'($urandom_range(0, 7));
            if (ena) ena = ($urandom_range(0, 99) != 0);
            else     ena = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 499) == 0);
            @(posedge clk);
            #2;
        end

        rst = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0; tick = 1'b0;
        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/field_select.md
# field_select

Parametrised field/digit selector for the clock's set-time UI, generalising the fixed 2-bit selector. It steps a field index 0..N_FIELDS-1 up or down from debounced button levels, with wrap or saturate mode, hold-to-auto-repeat driven by a shared timebase strobe, an optional idle timeout back to the home field, and a direct load. It sits between the button debouncers and the display/edit mux.

## Interface
- N_FIELDS, 4, number of selectable fields (2..2**VAL_W)
- VAL_W, 2, width of o_val
- RESET_VAL, 0, value after reset and after timeout (< N_FIELDS)
- SATURATE, 0, 0 = wrap at ends, 1 = hold at ends
- REPEAT_DELAY, 500, i_tick count from press to first auto-repeat step (>= 1)
- REPEAT_RATE, 100, i_tick count between auto-repeat steps (>= 1)
- TIMEOUT_TICKS, 0, idle i_tick count before return to RESET_VAL; 0 disables
- CNT_W, 16, width of tick counters (must hold max of the three counts)

- i_clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_ena  in  1  block enable
- i_tick  in  1  one-cycle timebase strobe (e.g. 1 kHz)
- i_inc  in  1  debounced increment button level
- i_dec  in  1  debounced decrement button level
- i_load  in  1  load request, one cycle
- i_load_val  in  VAL_W  value to load
- o_val  out  VAL_W  selected field index, registered
- o_step  out  1  one-cycle pulse when o_val changed by a button step
- o_wrap  out  1  one-cycle pulse on wrap (WRAP) or blocked step at an end (SATURATE)
- o_timeout  out  1  one-cycle pulse when timeout returns o_val to RESET_VAL
- o_repeating  out  1  high while in auto-repeat

## Operation
- Reset: o_val=RESET_VAL; o_step, o_wrap, o_timeout, o_repeating = 0; FSM IDLE; counters 0; button-history regs set to 1 so a button held through reset does not step until released and re-pressed.
- Press = rising edge of i_inc/i_dec against its history reg (history updates every cycle, including while i_ena=0).
- FSM states: IDLE, DELAY, REPEAT, LOCK.
  - IDLE: press on exactly one button -> step once, counter=0, go DELAY.
  - DELAY: count i_tick; at REPEAT_DELAY ticks -> step, counter=0, go REPEAT.
  - REPEAT: count i_tick; every REPEAT_RATE ticks -> step. o_repeating=1 only here.
  - DELAY/REPEAT: active button released -> IDLE. Other button pressed -> LOCK.
  - Both buttons high in IDLE -> LOCK. LOCK: no steps; -> IDLE when both low.
- i_ena=0: no steps, no loads, FSM forced IDLE, timeout counter held at 0; o_val holds.
- Step arithmetic: inc at N_FIELDS-1 -> 0 (WRAP) or hold (SATURATE); dec at 0 -> N_FIELDS-1 (WRAP) or hold. o_wrap pulses in both end cases; o_step pulses only if o_val changed.
- Load (i_ena=1): o_val=min(i_load_val, N_FIELDS-1); priority over a same-cycle step (step discarded, FSM still advances); no o_step/o_wrap; restarts timeout counter.
- Timeout (TIMEOUT_TICKS>0): counter counts i_tick while FSM IDLE and no button high; cleared by any press, step or load. At TIMEOUT_TICKS -> o_val=RESET_VAL, o_timeout pulse, counter=0. Fires even if o_val already RESET_VAL.

## Timing
- Press sampled in cycle t -> o_val and o_step/o_wrap valid from cycle t+1 (one clock latency).
- Auto-repeat steps land one cycle after the qualifying i_tick; first repeat at the REPEAT_DELAY-th tick after the press cycle, then every REPEAT_RATE ticks.
- i_tick coincident with press cycle is not counted.
- Reset mid-DELAY/REPEAT: next cycle IDLE, outputs at reset values; held button ignored until re-pressed.
- All outputs registered; pulses exactly one cycle.

## Test plan
- N_FIELDS=4, WRAP: four inc presses from 0 -> o_val 1,2,3,0; o_wrap on 3->0 only; one dec at 0 -> 3 with o_wrap.
- N_FIELDS=6, SATURATE: inc at 5 -> o_val stays 5, o_wrap=1, o_step=0; dec at 0 likewise.
- REPEAT_DELAY=3, REPEAT_RATE=2: hold i_inc for 9 ticks -> steps at press, tick 3, 5, 7, 9 (o_val 0->5 mod N); o_repeating high from tick 3 to release.
- Both buttons pressed together -> no step, LOCK; release i_dec only -> still no step; release both then press i_inc -> one step.
- TIMEOUT_TICKS=5, o_val=2, idle 5 ticks -> o_val=0, o_timeout pulse; press at tick 4 -> no timeout.
- Load 7 with N_FIELDS=4 -> o_val=3; load coincident with inc press -> load wins; i_inc held through i_reset -> no step after reset.
